// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 command decoder and driver: column count,
// command opcodes and the range-command decoder state encoding.
package ssd1306_pkg;

    localparam int COLS = 128;

    localparam logic [7:0] CMD_SET_COL_RANGE  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE_RANGE = 8'h22;
    localparam logic [7:0] CMD_ADDR_MODE      = 8'h20;
    localparam logic [7:0] CMD_CONTRAST       = 8'h81;
    localparam logic [7:0] CMD_CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] CMD_MUX_RATIO      = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET    = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV        = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE      = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS       = 8'hDA;
    localparam logic [7:0] CMD_VCOMH          = 8'hDB;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COL_START  = 3'd1,
        COL_END    = 3'd2,
        PAGE_START = 3'd3,
        PAGE_END   = 3'd4,
        SKIP1      = 3'd5
    } dec_state_e;

    // Commands whose single argument byte carries no addressing information.
    function automatic logic has_skip_arg(input logic [7:0] cmd);
        logic hit;
        case (cmd)
            CMD_ADDR_MODE, CMD_CONTRAST, CMD_CHARGE_PUMP, CMD_MUX_RATIO,
            CMD_DISP_OFFSET, CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS,
            CMD_VCOMH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ssd1306_spi_deser.sv
// SPI mode-0 byte deserializer: input synchronizers, edge detection, MSB-first
// shifting and detection of chip select released mid-byte.
module ssd1306_spi_deser
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    output logic [7:0] byte_out,
    output logic       byte_dc,
    output logic       byte_rdy,
    output logic       byte_valid,
    output logic       frame_err
);

    // Each stage holds {csn, clk, mosi, dc}; csn presets high so reset never fakes an edge.
    localparam logic [3:0] SYNC_RESET = 4'b1000;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic       csn_prev_q, csn_prev_d;
    logic       clk_prev_q, clk_prev_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_dc_q, byte_dc_d;
    logic       rdy_q, rdy_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    logic csn_s, clk_s, mosi_s, dc_s;
    logic clk_rise_s, csn_rise_s;

    // Next-state logic for synchronizers, shifter and strobes.
    always_comb begin
        sync_d[0] = {spi_csn, spi_clk, spi_mosi, spi_dc};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        {csn_s, clk_s, mosi_s, dc_s} = sync_q[SYNC_STAGES-1];
        clk_rise_s = clk_s & ~clk_prev_q;
        csn_rise_s = csn_s & ~csn_prev_q;

        csn_prev_d = csn_s;
        clk_prev_d = clk_s;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        byte_out_d = byte_out_q;
        byte_dc_d  = byte_dc_q;
        rdy_d      = 1'b0;
        valid_d    = rdy_q;
        ferr_d     = 1'b0;

        if (csn_rise_s) begin
            cnt_d  = 3'd0;
            ferr_d = (cnt_q != 3'd0);
        end else if (clk_rise_s && !csn_s) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_out_d = {shift_q, mosi_s};
                byte_dc_d  = dc_s;
                rdy_d      = 1'b1;
            end else begin
                rdy_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync_q     <= {SYNC_STAGES{SYNC_RESET}};
            csn_prev_q <= 1'b1;
            clk_prev_q <= 1'b0;
            shift_q    <= 7'd0;
            cnt_q      <= 3'd0;
            byte_out_q <= 8'd0;
            byte_dc_q  <= 1'b0;
            rdy_q      <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            csn_prev_q <= csn_prev_d;
            clk_prev_q <= clk_prev_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            byte_out_q <= byte_out_d;
            byte_dc_q  <= byte_dc_d;
            rdy_q      <= rdy_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_dc    = byte_dc_q;
    assign byte_rdy   = rdy_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 SPI receiver: decodes column/page range commands and turns display
// data bytes into framebuffer writes using horizontal addressing.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int PAGES       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic                           spi_csn,
    input  logic                           spi_clk,
    input  logic                           spi_mosi,
    input  logic                           spi_dc,
    output logic [7:0]                     byte_out,
    output logic                           byte_dc,
    output logic                           byte_valid,
    output logic                           fb_we,
    output logic [$clog2(PAGES*COLS)-1:0]  fb_addr,
    output logic [7:0]                     fb_data,
    output logic                           frame_err
);

    localparam int PW = $clog2(PAGES);
    localparam int AW = $clog2(PAGES*COLS);
    localparam logic [PW-1:0] PAGE_ONE  = PW'(1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES-1);

    logic des_rdy;

    ssd1306_spi_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .spi_csn    (spi_csn),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .byte_out   (byte_out),
        .byte_dc    (byte_dc),
        .byte_rdy   (des_rdy),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    dec_state_e     state_q, state_d;
    logic [6:0]     col_q, col_d;
    logic [6:0]     col_start_q, col_start_d;
    logic [6:0]     col_end_q, col_end_d;
    logic [PW-1:0]  page_q, page_d;
    logic [PW-1:0]  page_start_q, page_start_d;
    logic [PW-1:0]  page_end_q, page_end_d;
    logic           fb_we_q, fb_we_d;
    logic [AW-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]     fb_data_q, fb_data_d;

    // Command decoder and pointer advance; the framebuffer write lines up with byte_valid.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_d       = page_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;

        if (des_rdy) begin
            if (byte_dc) begin
                // A data byte cancels any half-finished range command.
                state_d   = IDLE;
                fb_we_d   = 1'b1;
                fb_addr_d = {page_q, col_q};
                fb_data_d = byte_out;
                if (col_q == col_end_q) begin
                    col_d = col_start_q;
                    if (page_q == page_end_q) begin
                        page_d = page_start_q;
                    end else begin
                        page_d = page_q + PAGE_ONE;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (byte_out == CMD_SET_COL_RANGE) begin
                            state_d = COL_START;
                        end else if (byte_out == CMD_SET_PAGE_RANGE) begin
                            state_d = PAGE_START;
                        end else if (has_skip_arg(byte_out)) begin
                            state_d = SKIP1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    COL_START: begin
                        col_start_d = byte_out[6:0];
                        col_d       = byte_out[6:0];
                        state_d     = COL_END;
                    end
                    COL_END: begin
                        col_end_d = byte_out[6:0];
                        state_d   = IDLE;
                    end
                    PAGE_START: begin
                        page_start_d = byte_out[PW-1:0];
                        page_d       = byte_out[PW-1:0];
                        state_d      = PAGE_END;
                    end
                    PAGE_END: begin
                        page_end_d = byte_out[PW-1:0];
                        state_d    = IDLE;
                    end
                    SKIP1: begin
                        state_d = IDLE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            fb_we_d = 1'b0;
        end
    end

    // Decoder state, range registers, pointers and registered write port.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            col_q        <= 7'd0;
            col_start_q  <= 7'd0;
            col_end_q    <= 7'd127;
            page_q       <= '0;
            page_start_q <= '0;
            page_end_q   <= PAGE_LAST;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_q       <= page_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
        end
    end

    assign fb_we   = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Self-checking bench: directed scenarios plus a random command/data stream
// checked against an address-arithmetic reference model of the display controller.
module tb_ssd1306_spi_receiver;

    localparam int PAGES    = 4;
    localparam int AW       = $clog2(PAGES*128);
    localparam int SPI_HALF = 20;
    localparam logic [7:0] CMD_TBL [8] = '{8'h21, 8'h22, 8'h20, 8'h81, 8'hD3, 8'hAE, 8'hA5, 8'hDB};

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          spi_csn = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_dc = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_dc;
    logic          byte_valid;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          frame_err;

    ssd1306_spi_receiver #(.PAGES(PAGES), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .spi_csn(spi_csn), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_dc(spi_dc), .byte_out(byte_out), .byte_dc(byte_dc),
        .byte_valid(byte_valid), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_err(frame_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] obs_byte[$];
    int         obs_addr[$];
    logic [7:0] obs_data[$];
    int         n_ferr = 0;
    int         n_strobe_bad = 0;

    logic [8:0] exp_byte[$];
    int         exp_addr[$];
    logic [7:0] exp_data[$];

    // Reference model state: ranges, pointers and the opcode still waiting for arguments.
    int m_cs, m_ce, m_ps, m_pe, m_col, m_page, m_pend, m_argi;

    always @(negedge clk_in) begin
        if (!reset_in) begin
            if (byte_valid) obs_byte.push_back({byte_dc, byte_out});
            if (fb_we) begin
                obs_addr.push_back(int'(fb_addr));
                obs_data.push_back(fb_data);
            end
            if (frame_err) n_ferr = n_ferr + 1;
            if ((fb_we !== (byte_valid & byte_dc)) || (fb_we && (fb_data !== byte_out)))
                n_strobe_bad = n_strobe_bad + 1;
        end
    end

    task automatic model_reset();
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = PAGES - 1;
        m_col = 0; m_page = 0; m_pend = 0; m_argi = 0;
        exp_byte.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic model_byte(input logic dc, input logic [7:0] b);
        exp_byte.push_back({dc, b});
        if (dc) begin
            m_pend = 0;
            exp_addr.push_back(m_page * 128 + m_col);
            exp_data.push_back(b);
            if (m_col == m_ce) begin
                m_col  = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
            end else begin
                m_col = (m_col + 1) % 128;
            end
        end else if (m_pend == 'h21) begin
            if (m_argi == 0) begin m_cs = b % 128; m_col = m_cs; m_argi = 1; end
            else begin m_ce = b % 128; m_pend = 0; end
        end else if (m_pend == 'h22) begin
            if (m_argi == 0) begin m_ps = b % PAGES; m_page = m_ps; m_argi = 1; end
            else begin m_pe = b % PAGES; m_pend = 0; end
        end else if (m_pend != 0) begin
            m_pend = 0;
        end else if (b == 8'h21 || b == 8'h22) begin
            m_pend = b; m_argi = 0;
        end else if (b inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) begin
            m_pend = b;
        end
    endtask

    task automatic clear_obs();
        obs_byte.delete(); obs_addr.delete(); obs_data.delete();
        n_ferr = 0; n_strobe_bad = 0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 reset_in = 1'b0;
        model_reset();
        clear_obs();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            #SPI_HALF spi_clk = 1'b1;
            #SPI_HALF spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        spi_dc = dc;
        send_bits(b, 8);
        model_byte(dc, b);
    endtask

    task automatic csn_low();  spi_csn = 1'b0; #SPI_HALF; endtask
    task automatic csn_high(); #SPI_HALF spi_csn = 1'b1; #(SPI_HALF*2); endtask
    task automatic settle();   repeat (12) @(posedge clk_in); endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        n_checks++;
        if (byte_out !== 8'h00 || byte_dc !== 1'b0) begin
            n_fail++; $display("FAIL reset_byte: got %h/%b want 00/0", byte_out, byte_dc);
        end
        n_checks++;
        if ({byte_valid, fb_we, frame_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000", {byte_valid, fb_we, frame_err});
        end
        n_checks++;
        if (fb_addr !== '0 || fb_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_fb: got addr %0d data %h want 0/00", fb_addr, fb_data);
        end
    endtask

    task automatic test_reset_mid_byte();
        do_reset();
        csn_low();
        spi_dc = 1'b1;
        send_bits(8'hA5, 4);
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;
        csn_high();
        settle();
        n_checks++;
        if (n_ferr != 0 || obs_byte.size() != 0) begin
            n_fail++; $display("FAIL reset_mid_byte: got ferr %0d bytes %0d want 0/0", n_ferr, obs_byte.size());
        end
        csn_low();
        send_byte(1'b1, 8'h5A);
        csn_high();
        settle();
        n_checks++;
        if (!(obs_byte.size() == 1 && obs_byte[0] === 9'h15A)) begin
            n_fail++; $display("FAIL after_reset_byte: got %0d bytes want one 15a", obs_byte.size());
        end
    endtask

    task automatic test_basic();
        do_reset();
        csn_low();
        send_byte(1'b1, 8'hC3);
        csn_high();
        settle();
        n_checks++;
        if (!(obs_byte.size() == 1 && obs_byte[0] === 9'h1C3)) begin
            n_fail++; $display("FAIL basic_byte: got %0d bytes want one (dc=1, C3)", obs_byte.size());
        end
        n_checks++;
        if (!(obs_addr.size() == 1 && obs_addr[0] == 0 && obs_data[0] === 8'hC3)) begin
            n_fail++; $display("FAIL basic_write: got %0d writes want one at 0 with C3", obs_addr.size());
        end
        n_checks++;
        if (n_strobe_bad != 0) begin
            n_fail++; $display("FAIL basic_strobe_align: got %0d bad cycles want 0", n_strobe_bad);
        end
    endtask

    task automatic test_range();
        int want[7] = '{133, 134, 135, 261, 262, 263, 133};
        do_reset();
        csn_low();
        send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h07);
        send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h02);
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'($urandom));
        csn_high();
        settle();
        n_checks++;
        if (obs_addr.size() != 7) begin
            n_fail++; $display("FAIL range_count: got %0d writes want 7", obs_addr.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (obs_addr[i] != want[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL range_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], want[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_skip();
        do_reset();
        csn_low();
        send_byte(1'b0, 8'h81); send_byte(1'b0, 8'h21);
        send_byte(1'b1, 8'hAA); send_byte(1'b1, 8'h55);
        csn_high();
        settle();
        n_checks++;
        if (!(obs_addr.size() == 2 && obs_addr[0] == 0 && obs_addr[1] == 1 && obs_data[0] === 8'hAA)) begin
            n_fail++; $display("FAIL skip_write: got %0d writes (first at %0d) want AA at 0 then 1", obs_addr.size(), obs_addr.size() ? obs_addr[0] : -1);
        end
    endtask

    task automatic test_partial();
        do_reset();
        csn_low();
        spi_dc = 1'b1;
        send_bits(8'hFF, 5);
        csn_high();
        settle();
        n_checks++;
        if (n_ferr != 1 || obs_byte.size() != 0) begin
            n_fail++; $display("FAIL partial: got ferr %0d bytes %0d want 1/0", n_ferr, obs_byte.size());
        end
        csn_low();
        send_byte(1'b1, 8'h3C);
        csn_high();
        settle();
        n_checks++;
        if (!(n_ferr == 1 && obs_byte.size() == 1 && obs_byte[0] === 9'h13C && obs_addr.size() == 1 && obs_addr[0] == 0)) begin
            n_fail++; $display("FAIL partial_recover: got ferr %0d bytes %0d want 1/one 13c at 0", n_ferr, obs_byte.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        csn_low();
        send_byte(1'b0, 8'h21);
        send_byte(1'b1, 8'h11);
        send_byte(1'b0, 8'h00);
        send_byte(1'b1, 8'h22);
        csn_high();
        settle();
        n_checks++;
        if (!(obs_addr.size() == 2 && obs_addr[0] == 0 && obs_addr[1] == 1 && obs_data[0] === 8'h11)) begin
            n_fail++; $display("FAIL abort: got %0d writes want 11 at 0 then write at 1", obs_addr.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        csn_low();
        for (int i = 0; i < 513; i++) send_byte(1'b1, 8'($urandom));
        csn_high();
        settle();
        n_checks++;
        if (!(obs_addr.size() == 513 && obs_addr[511] == 511 && obs_addr[512] == 0)) begin
            n_fail++; $display("FAIL wrap: got %0d writes want 513 ending 511,0", obs_addr.size());
        end
        n_checks++;
        if (obs_data != exp_data) begin
            n_fail++; $display("FAIL wrap_data: got %0d data bytes want %0d matching", obs_data.size(), exp_data.size());
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        csn_low();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) send_byte(1'b1, 8'($urandom));
            else if (r < 7) send_byte(1'b0, CMD_TBL[$urandom_range(0, 7)]);
            else send_byte(1'b0, 8'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                csn_high();
                csn_low();
            end
        end
        csn_high();
        settle();
        n_checks++;
        if (obs_byte.size() != exp_byte.size() || obs_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL random_counts: got %0d bytes %0d writes want %0d/%0d",
                               obs_byte.size(), obs_addr.size(), exp_byte.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_checks++;
                if (obs_addr[i] != exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL random_write[%0d]: got %0d/%h want %0d/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
            n_checks++;
            if (obs_byte != exp_byte) begin
                n_fail++; $display("FAIL random_bytes: received byte stream differs from sent stream");
            end
        end
        n_checks++;
        if (n_ferr != 0 || n_strobe_bad != 0) begin
            n_fail++; $display("FAIL random_strobes: got ferr %0d bad %0d want 0/0", n_ferr, n_strobe_bad);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_byte();
        test_basic();
        test_range();
        test_skip();
        test_partial();
        test_abort();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
